// File: rtl/bp_pkg.sv
// Shared types and helpers for the backward-pass weight-update engine:
// FSM state encoding, index-width helper and signed saturation limits.
package bp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        UPD  = 2'd2,
        DONE = 2'd3
    } bp_state_t;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Largest value representable in a w-bit two's complement number.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit two's complement number.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/bp_sat_sub.sv
// Signed subtract (w - grad) computed at full width, then saturated
// into a W_W-bit signed result. Purely combinational.
module bp_sat_sub
    import bp_pkg::*;
#(
    parameter int W_W = 8,
    parameter int G_W = 30
) (
    input  logic signed [W_W-1:0] w,
    input  logic signed [G_W-1:0] grad,
    output logic signed [W_W-1:0] result
);

    // One guard bit above the wider operand keeps the difference exact.
    localparam int D_W = ((G_W > W_W) ? G_W : W_W) + 1;
    localparam logic signed [D_W-1:0] MAX_V = D_W'(sat_max(W_W));
    localparam logic signed [D_W-1:0] MIN_V = D_W'(sat_min(W_W));

    logic signed [D_W-1:0] diff;

    // Exact difference followed by clamping to the weight range.
    always_comb begin
        diff = D_W'(w) - D_W'(grad);
        if (diff > MAX_V) begin
            result = MAX_V[W_W-1:0];
        end else if (diff < MIN_V) begin
            result = MIN_V[W_W-1:0];
        end else begin
            result = diff[W_W-1:0];
        end
    end

endmodule

// File: rtl/bp_weight_update_engine.sv
// Backward-pass weight-update engine for one neuron. On start it snapshots
// target/final/x/w, computes err = target - final, then rewrites one weight
// per cycle with w - ((2*err*x) >>> LR_SHIFT), saturated to W_W bits, and
// emits a write-back strobe for each. Optional gradient clipping is enabled
// by defining BP_GRAD_CLIP_EN (clamps the gradient to +/-GRAD_MAX).
module bp_weight_update_engine
    import bp_pkg::*;
#(
    parameter int N_W      = 4,
    parameter int W_W      = 8,
    parameter int X_W      = 4,
    parameter int Y_W      = 23,
    parameter int LR_SHIFT = 2,
    parameter int GRAD_MAX = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      zero_weight_reset_i,
    input  logic                      start_i,
    input  logic [X_W-1:0]            target_i,
    input  logic signed [Y_W-1:0]     final_i,
    input  logic [N_W*X_W-1:0]        x_i,
    input  logic [N_W*W_W-1:0]        w_i,
    output logic [N_W*W_W-1:0]        w_o,
    output logic                      wb_we_o,
    output logic [idx_w(N_W)-1:0]     wb_idx_o,
    output logic signed [W_W-1:0]     wb_data_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int IW  = idx_w(N_W);
    localparam int E_W = Y_W + 1;
    localparam int P_W = Y_W + X_W + 3;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_W - 1);

    bp_state_t state_reg, state_next;

    logic [X_W-1:0]        x_in       [N_W];
    logic signed [W_W-1:0] w_in       [N_W];
    logic [X_W-1:0]        x_snap_reg [N_W];
    logic signed [W_W-1:0] w_snap_reg [N_W];
    logic signed [W_W-1:0] w_reg      [N_W];

    logic [X_W-1:0]        target_snap_reg;
    logic signed [Y_W-1:0] final_snap_reg;
    logic signed [E_W-1:0] err_reg;
    logic signed [E_W-1:0] err_next;
    logic [IW-1:0]         idx_reg;

    logic                  wb_we_reg;
    logic [IW-1:0]         wb_idx_reg;
    logic signed [W_W-1:0] wb_data_reg;
    logic                  done_reg;

    logic [X_W-1:0]        x_cur;
    logic signed [W_W-1:0] w_cur;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] grad_shift;
    logic signed [P_W-1:0] grad;
    logic signed [W_W-1:0] w_new;

    // Unpack the flat buses into per-weight views and repack the result.
    generate
        for (genvar gi = 0; gi < N_W; gi++) begin : g_lane
            assign x_in[gi]              = x_i[gi*X_W +: X_W];
            assign w_in[gi]              = w_i[gi*W_W +: W_W];
            assign w_o[gi*W_W +: W_W]    = w_reg[gi];
        end
    endgenerate

    assign wb_we_o   = wb_we_reg;
    assign wb_idx_o  = wb_idx_reg;
    assign wb_data_o = wb_data_reg;
    assign done_o    = done_reg;
    assign busy_o    = (state_reg == ERR) || (state_reg == UPD);

    // Error term: zero-extended target minus sign-extended final output.
    assign err_next = E_W'($signed({1'b0, target_snap_reg})) - E_W'(final_snap_reg);

    // Gradient for the weight currently addressed by the index counter.
    always_comb begin
        x_cur      = x_snap_reg[idx_reg];
        w_cur      = w_snap_reg[idx_reg];
        prod       = (P_W'(err_reg) * P_W'($signed({1'b0, x_cur}))) <<< 1;
        grad_shift = prod >>> LR_SHIFT;
        grad       = grad_shift;
`ifdef BP_GRAD_CLIP_EN
        if (grad_shift > P_W'(GRAD_MAX)) begin
            grad = P_W'(GRAD_MAX);
        end else if (grad_shift < -P_W'(GRAD_MAX)) begin
            grad = -P_W'(GRAD_MAX);
        end
`endif
    end

    bp_sat_sub #(
        .W_W (W_W),
        .G_W (P_W)
    ) u_sat_sub (
        .w      (w_cur),
        .grad   (grad),
        .result (w_new)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; the synchronous clear wins over everything.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = ERR;
            ERR:     state_next = UPD;
            UPD:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (zero_weight_reset_i) begin
            state_next = IDLE;
        end
    end

    // Snapshot, error, index and write-back registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_W; i++) begin
                x_snap_reg[i] <= '0;
                w_snap_reg[i] <= '0;
                w_reg[i]      <= '0;
            end
            target_snap_reg <= '0;
            final_snap_reg  <= '0;
            err_reg         <= '0;
            idx_reg         <= '0;
            wb_we_reg       <= 1'b0;
            wb_idx_reg      <= '0;
            wb_data_reg     <= '0;
            done_reg        <= 1'b0;
        end else if (zero_weight_reset_i) begin
            for (int i = 0; i < N_W; i++) begin
                x_snap_reg[i] <= '0;
                w_snap_reg[i] <= '0;
                w_reg[i]      <= '0;
            end
            target_snap_reg <= '0;
            final_snap_reg  <= '0;
            err_reg         <= '0;
            idx_reg         <= '0;
            wb_we_reg       <= 1'b0;
            wb_idx_reg      <= '0;
            wb_data_reg     <= '0;
            done_reg        <= 1'b0;
        end else begin
            wb_we_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i < N_W; i++) begin
                            x_snap_reg[i] <= x_in[i];
                            w_snap_reg[i] <= w_in[i];
                        end
                        target_snap_reg <= target_i;
                        final_snap_reg  <= final_i;
                    end
                end
                ERR: begin
                    err_reg <= err_next;
                    idx_reg <= '0;
                end
                UPD: begin
                    w_reg[idx_reg] <= w_new;
                    wb_we_reg      <= 1'b1;
                    wb_idx_reg     <= idx_reg;
                    wb_data_reg    <= w_new;
                    if (idx_reg != LAST_IDX) begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/bp_weight_update_engine.md
Name: bp_weight_update_engine

Overview:
- Parametrised sequential weight-update engine for one neuron's incoming weights during the backward pass.
- On `start_i` it snapshots the error inputs and N_W weights, then updates one weight per cycle:
  - gradient = (2 · err · x_k) >>> LR_SHIFT
  - new weight = saturating subtract of the gradient from the weight
- Sits between the forward-pass neuron (supplies `final_i`, `x_i`) and the weight register file (consumes per-weight write-backs). Signals completion with `done_o`.

Parameters:
- N_W, 4, number of weights/inputs per neuron (≥1)
- W_W, 8, signed weight width
- X_W, 4, unsigned input activation width
- Y_W, 23, signed width of `final_i`
- LR_SHIFT, 2, learning-rate right shift applied to the gradient
- GRAD_MAX, 64, gradient magnitude clip limit (used only with BP_GRAD_CLIP_EN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- zero_weight_reset_i  in  1  synchronous clear of weights/state
- start_i  in  1  begin update (accepted only in IDLE)
- target_i  in  X_W  unsigned training target
- final_i  in  Y_W  signed neuron output
- x_i  in  N_W*X_W  packed inputs; slice k = x_i[k*X_W +: X_W]
- w_i  in  N_W*W_W  packed current weights, signed
- w_o  out  N_W*W_W  registered updated weights
- wb_we_o  out  1  one-cycle write-back strobe per updated weight
- wb_idx_o  out  clog2(N_W) (min 1)  index of the weight being written back
- wb_data_o  out  W_W  new weight value
- busy_o  out  1  high in ERR and UPD
- done_o  out  1  one-cycle pulse at completion

Behaviour:
- Reset (`rst_i` high, async): state=IDLE; `w_o`=0, `wb_we_o`=0, `wb_idx_o`=0, `wb_data_o`=0, `busy_o`=0, `done_o`=0, index counter=0.
- FSM states: IDLE, ERR, UPD, DONE.
  - IDLE: on `start_i`, latch `x_i`, `w_i`, `target_i`, `final_i` into snapshot registers → ERR.
  - ERR: err = zero-extended target − sign-extended final, width Y_W+1 signed, registered; index=0 → UPD.
  - UPD: one weight per cycle; on index==N_W−1 → DONE, otherwise index+1.
  - DONE: `done_o`=1 for exactly one cycle → IDLE.
- Arithmetic per weight k:
  - prod = 2·err·zext(x_k), full width Y_W+X_W+3 signed, no truncation.
  - grad = prod >>> LR_SHIFT (arithmetic shift, floors toward −∞).
  - sum = sext(w_k) − grad at full width, then saturate to [−2^(W_W−1), 2^(W_W−1)−1].
- UPD cycle k (registered outputs, visible next edge):
  - `w_o` slice k ← saturated value; `wb_we_o`=1; `wb_idx_o`=k; `wb_data_o`=saturated value.
  - Untouched slices of `w_o` hold their previous values.
- Latency: `start_i` sampled at edge 0 → write-backs at edges 2..N_W+1 → `done_o` high after edge N_W+2.
- `start_i` outside IDLE is ignored; inputs are not re-sampled during an update.
- err==0 or x_k==0 → weight k written back unchanged (`wb_we_o` still pulses).
- `zero_weight_reset_i` (synchronous) overrides `start_i` and all states: state→IDLE, `w_o`=0, strobes low, no `done_o`.
- Async reset mid-update aborts immediately; no `done_o` is emitted.
- `start_i` in the DONE cycle is ignored; a new start is accepted from IDLE on the following cycle.

Optional Feature:
- Macro BP_GRAD_CLIP_EN.
- Defined: grad is clamped to [−GRAD_MAX, GRAD_MAX] after the shift and before the subtraction.
- Undefined: no clamp; only output saturation applies. GRAD_MAX is unused.

Decomposition:
- Package `bp_pkg`: FSM state enum (IDLE/ERR/UPD/DONE), `idx_w` helper function (clog2, min 1), saturation-limit constant functions of W_W.
- Sub-module `bp_sat_sub`: parametrised signed full-width subtract with saturation to W_W. Instantiated once; one weight is processed per cycle.

Test Plan:
- Basic update: N_W=4, target=5, final=3, x0=3, w0=10 → err=2, grad=3, `wb_idx_o`=0 with `wb_data_o`=7; `done_o` after N_W+2 cycles from start.
- Positive saturation: target=0, final=100, x=15, w=−120 → grad=−750 → `wb_data_o`=127. Negative saturation: target=15, final=0, x=15, w=−120 → grad=112 → −128.
- Floor rounding: target=0, final=1, x=1, w=0 → prod=−2, grad=−1 → `wb_data_o`=1. With all x=0, every weight is written back unchanged.
- Handshake: pulse `start_i` during UPD and during DONE → ignored; exactly one `done_o` and exactly N_W `wb_we_o` pulses per accepted start.
- Abort paths: assert `rst_i` mid-UPD → all outputs 0 immediately, no `done_o`. Assert `zero_weight_reset_i` together with `start_i` in IDLE → `w_o`=0, remains IDLE.
- BP_GRAD_CLIP_EN with GRAD_MAX=64: target=0, final=100, x=15, w=−120 → grad clamped to −64 → `wb_data_o`=−56.
